// File: rtl/dm_mem_if.sv
// Data memory port bundle: request side (ce/we/re/be/addr/din/pc) driven by
// the access unit, response side (dout/ready) driven by the memory.
//   master : access unit (drives mem_ce/we/re/be/addr/din/pc, reads dout/ready)
//   slave  : memory      (reads request fields, drives mem_dout/mem_ready)
interface dm_mem_if;
  logic [31:0] mem_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_ce;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_dout;
  logic        mem_ready;

  modport master (
    output mem_pc, mem_addr, mem_din, mem_ce, mem_we, mem_re, mem_be,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_pc, mem_addr, mem_din, mem_ce, mem_we, mem_re, mem_be,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage data memory initiator. Accepts one load/store from the pipeline,
// checks alignment and address range, drives the memory port with byte
// enables and lane-replicated store data, waits for mem_ready (with a bus
// error timeout), then returns an extended load result for one cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/op/addr/wdata/pc   request from pipeline (held while stall=1)
//   stall                 combinational freeze of upstream stages
//   resp_valid/rdata      one-cycle completion strobe and load result
//   exc_valid/exc_code    exception on this response (4 AdEL, 5 AdES, 7 DBE)
//   mem                   data memory port (dm_mem_if.master)
module dm_access_unit #(
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  dm_mem_if.master    mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;

  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] mem_pc_q, mem_pc_d;

  logic        resp_valid_d;
  logic [31:0] resp_rdata_d;
  logic        exc_valid_d;
  logic [4:0]  exc_code_d;

  logic        req_store;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request decode: ops 5..7 are stores, the rest loads.
  assign req_store        = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);
  assign req_out_of_range = (req_addr >= ADDR_LIMIT);
  assign req_fault        = req_misaligned | req_out_of_range;

  always_comb begin
    req_misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         req_misaligned = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      default:              req_misaligned = 1'b0;
    endcase
  end

  // Lane selection uses the registered address, which is held through ACCESS.
  assign ld_byte = mem.mem_dout[{mem_addr_q[1:0], 3'b000} +: 8];
  assign ld_half = mem.mem_dout[{mem_addr_q[1], 4'b0000} +: 16];

  // Stall until the response cycle, where the pipeline is allowed to advance.
  assign stall = req_valid & ~resp_valid;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    mem_ce_d     = mem_ce_q;
    mem_we_d     = mem_we_q;
    mem_re_d     = mem_re_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_pc_d     = mem_pc_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    exc_valid_d  = 1'b0;
    exc_code_d   = EXC_NONE;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (req_fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            exc_valid_d  = 1'b1;
            exc_code_d   = req_store ? EXC_ADES : EXC_ADEL;
          end else begin
            state_d    = ST_ACCESS;
            op_d       = req_op;
            mem_ce_d   = 1'b1;
            mem_we_d   = req_store;
            mem_re_d   = ~req_store;
            mem_addr_d = req_addr;
            mem_pc_d   = req_pc;
            case (req_op)
              OP_SW: begin
                mem_be_d  = 4'b1111;
                mem_din_d = req_wdata;
              end
              OP_SH: begin
                mem_be_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_din_d = {2{req_wdata[15:0]}};
              end
              OP_SB: begin
                mem_be_d  = 4'b0001 << req_addr[1:0];
                mem_din_d = {4{req_wdata[7:0]}};
              end
              default: begin
                mem_be_d  = 4'b1111;
                mem_din_d = 32'd0;
              end
            endcase
          end
        end
      end

      ST_ACCESS: begin
        // Ready wins over a timeout landing on the same edge.
        if (mem.mem_ready || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          mem_ce_d     = 1'b0;
          mem_we_d     = 1'b0;
          mem_re_d     = 1'b0;
          mem_be_d     = 4'b0000;
          mem_addr_d   = 32'd0;
          mem_din_d    = 32'd0;
          mem_pc_d     = 32'd0;
          if (mem.mem_ready) begin
            case (op_q)
              OP_LW:   resp_rdata_d = mem.mem_dout;
              OP_LH:   resp_rdata_d = {{16{ld_half[15]}}, ld_half};
              OP_LHU:  resp_rdata_d = {16'd0, ld_half};
              OP_LB:   resp_rdata_d = {{24{ld_byte[7]}}, ld_byte};
              OP_LBU:  resp_rdata_d = {24'd0, ld_byte};
              default: resp_rdata_d = 32'd0;
            endcase
          end else begin
            exc_valid_d = 1'b1;
            exc_code_d  = EXC_DBE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= 3'd0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      mem_pc_q   <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      exc_valid  <= 1'b0;
      exc_code   <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_pc_q   <= mem_pc_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      exc_valid  <= exc_valid_d;
      exc_code   <= exc_code_d;
    end
  end

  assign mem.mem_ce   = mem_ce_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.mem_re   = mem_re_q;
  assign mem.mem_be   = mem_be_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;
  assign mem.mem_pc   = mem_pc_q;

endmodule
